// File: rtl/s27_pkg.sv
// s27_pkg: constants and helpers shared by the locked s27 array and its
// per-channel core.
//   FLOPS_PER_CH       - state flops per s27 channel (G5, G6, G7)
//   IDX_G5/IDX_G6/IDX_G7 - bit positions of each flop inside a channel's
//                        slice of the key, scan and state vectors
//   key_width()        - total key/scan width for a channel count
//   s27_in_t           - one channel's primary inputs
package s27_pkg;

    localparam int FLOPS_PER_CH = 3;

    localparam int IDX_G5 = 0;
    localparam int IDX_G6 = 1;
    localparam int IDX_G7 = 2;

    typedef struct packed {
        logic g0;
        logic g1;
        logic g2;
        logic g3;
    } s27_in_t;

    function automatic int key_width(input int channels);
        return FLOPS_PER_CH * channels;
    endfunction

endpackage

// File: rtl/s27_core.sv
// s27_core: one s27 channel. Combinational s27 next-state/output logic,
// three state flops (G5, G6, G7) with key gates on their D inputs and a
// scan mux that turns the flops into a 3-bit shift segment.
// Ports:
//   CLK, RST      - clock, asynchronous active-high reset
//   en            - functional state update enable
//   scan_en       - shift the scan segment (wins over en)
//   scan_si       - serial input into G5
//   scan_so       - serial output from G7
//   G0..G3        - s27 primary inputs
//   key, lock     - applied key bits and the correct key bits; each flop's
//                   D is inverted when they differ
//   G17           - s27 output, never key-gated
module s27_core
    import s27_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    scan_en,
    input  logic                    scan_si,
    output logic                    scan_so,
    input  logic                    G0,
    input  logic                    G1,
    input  logic                    G2,
    input  logic                    G3,
    input  logic [FLOPS_PER_CH-1:0] key,
    input  logic [FLOPS_PER_CH-1:0] lock,
    output logic                    G17
);

    logic [FLOPS_PER_CH-1:0] q;
    logic [FLOPS_PER_CH-1:0] d;
    logic g5, g6, g7;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

    assign g5 = q[IDX_G5];
    assign g6 = q[IDX_G6];
    assign g7 = q[IDX_G7];

    always_comb begin
        g14 = ~G0;
        g8  = g14 & g6;
        g12 = ~(G1 | g7);
        g15 = g12 | g8;
        g16 = G3 | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(G2 | g12);
    end

    assign G17 = ~g11;

    // key ^ lock is 0 for a correct key bit, so the flop sees the true s27
    // next state; any wrong bit inverts that flop's D.
    always_comb begin
        d = '0;
        d[IDX_G5] = g10 ^ key[IDX_G5] ^ lock[IDX_G5];
        d[IDX_G6] = g11 ^ key[IDX_G6] ^ lock[IDX_G6];
        d[IDX_G7] = g13 ^ key[IDX_G7] ^ lock[IDX_G7];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= '0;
        end else if (scan_en) begin
            q[IDX_G5] <= scan_si;
            q[IDX_G6] <= q[IDX_G5];
            q[IDX_G7] <= q[IDX_G6];
        end else if (en) begin
            q <= d;
        end
    end

    assign scan_so = q[IDX_G7];

endmodule

// File: rtl/s27_locked_array.sv
// s27_locked_array: CHANNELS independent key-locked s27 channels on one
// clock, with a serially loaded, sealable key register and a scan chain
// through every state flop.
// Ports:
//   CLK, RST      - clock, asynchronous active-high reset
//   en            - functional state update enable (all channels)
//   G0..G3        - per-channel s27 inputs, bit c feeds channel c
//   G17           - per-channel s27 output
//   scan_en       - shift the chain (wins over en)
//   scan_in       - chain input, enters ch0.G5
//   scan_out      - chain output from ch(CHANNELS-1).G7, blanked while
//                   sealed when SCAN_OBFUSCATE is set
//   key_in        - key serial data, enters at the MSB
//   key_shift     - shift key_in into the key register (unsealed only)
//   key_seal      - set the sticky sealed flag on the next edge
//   key_sealed    - sealed flag
module s27_locked_array
    import s27_pkg::*;
#(
    parameter int                             CHANNELS       = 4,
    parameter logic [FLOPS_PER_CH*CHANNELS-1:0] LOCK_KEY     = '0,
    parameter bit                             SCAN_OBFUSCATE = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic [CHANNELS-1:0] G0,
    input  logic [CHANNELS-1:0] G1,
    input  logic [CHANNELS-1:0] G2,
    input  logic [CHANNELS-1:0] G3,
    output logic [CHANNELS-1:0] G17,
    input  logic                scan_en,
    input  logic                scan_in,
    output logic                scan_out,
    input  logic                key_in,
    input  logic                key_shift,
    input  logic                key_seal,
    output logic                key_sealed
);

    localparam int W = key_width(CHANNELS);

    logic [W-1:0]                 key_reg;
    logic                         sealed;
    logic [CHANNELS:0]            chain;
    s27_in_t [CHANNELS-1:0]       ch_in;

    assign chain[0] = scan_in;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign ch_in[c] = '{g0: G0[c], g1: G1[c], g2: G2[c], g3: G3[c]};

        s27_core u_core (
            .CLK     (CLK),
            .RST     (RST),
            .en      (en),
            .scan_en (scan_en),
            .scan_si (chain[c]),
            .scan_so (chain[c+1]),
            .G0      (ch_in[c].g0),
            .G1      (ch_in[c].g1),
            .G2      (ch_in[c].g2),
            .G3      (ch_in[c].g3),
            .key     (key_reg[FLOPS_PER_CH*c +: FLOPS_PER_CH]),
            .lock    (LOCK_KEY[FLOPS_PER_CH*c +: FLOPS_PER_CH]),
            .G17     (G17[c])
        );
    end

    // The shift tests the old sealed value, so a shift issued together
    // with key_seal still lands before the register locks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_reg <= '0;
            sealed  <= 1'b0;
        end else begin
            if (key_shift && !sealed)
                key_reg <= {key_in, key_reg[W-1:1]};
            if (key_seal)
                sealed <= 1'b1;
        end
    end

    assign key_sealed = sealed;
    assign scan_out   = chain[CHANNELS] & ~(SCAN_OBFUSCATE & sealed);

endmodule

// File: tb/tb_s27_locked_array.sv
// Bench for s27_locked_array: two instances with different correct keys and
// scan-blanking settings share the functional and scan stimulus; each has
// its own key-load controls. A behavioural model (flat chain vector, s27
// equations, key shift register) is compared every cycle, and literal
// expectations pin the model at the points worked out by hand.
module tb_s27_locked_array;

    localparam logic [11:0] LK_A = 12'h000;
    localparam logic [11:0] LK_B = 12'h6C5;
    localparam logic [11:0] PAT  = 12'b1011_0011_1000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en, scan_en, scan_in;
    logic [3:0] G0, G1, G2, G3;
    logic [1:0] kin, ksh, kse;
    logic [3:0] g17_a, g17_b;
    logic       so_a, so_b, ks_a, ks_b;

    always #5 CLK = ~CLK;

    s27_locked_array #(.CHANNELS(4), .LOCK_KEY(LK_A), .SCAN_OBFUSCATE(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .en(en), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
        .G17(g17_a), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_a),
        .key_in(kin[0]), .key_shift(ksh[0]), .key_seal(kse[0]), .key_sealed(ks_a)
    );

    s27_locked_array #(.CHANNELS(4), .LOCK_KEY(LK_B), .SCAN_OBFUSCATE(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .en(en), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
        .G17(g17_b), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_b),
        .key_in(kin[1]), .key_shift(ksh[1]), .key_seal(kse[1]), .key_sealed(ks_b)
    );

    // Observation of internal state and key (actual values only).
    wire [11:0] st_a = {dut_a.g_ch[3].u_core.q, dut_a.g_ch[2].u_core.q,
                        dut_a.g_ch[1].u_core.q, dut_a.g_ch[0].u_core.q};
    wire [11:0] st_b = {dut_b.g_ch[3].u_core.q, dut_b.g_ch[2].u_core.q,
                        dut_b.g_ch[1].u_core.q, dut_b.g_ch[0].u_core.q};
    wire [11:0] key_a = dut_a.key_reg;
    wire [11:0] key_b = dut_b.key_reg;

    int nerr = 0;
    int nchk = 0;

    // Model: bit 3c+i of st is flop i of channel c, which is also its chain
    // position counted from scan_in. gst tracks an unlocked s27 reference.
    logic [11:0] st  [2];
    logic [11:0] gst [2];
    logic [11:0] kr  [2];
    logic        sl  [2];
    bit          gold_on = 0;
    int          mism [2];
    logic [3:0]  ga_last, gb_last;
    logic        sa_last, sb_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {G17, G13, G11, G10} of the original s27.
    function automatic logic [3:0] s27f(input logic g0, g1, g2, g3, g5, g6, g7);
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
        g14 = ~g0;           g8  = g14 & g6;      g12 = ~(g1 | g7);
        g15 = g12 | g8;      g16 = g3 | g8;       g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);    g10 = ~(g14 | g11);  g13 = ~(g2 | g12);
        return {~g11, g13, g11, g10};
    endfunction

    function automatic logic [3:0] model_g17(input logic [11:0] s);
        logic [3:0] o;
        logic [3:0] r;
        for (int c = 0; c < 4; c++) begin
            r = s27f(G0[c], G1[c], G2[c], G3[c], s[3*c], s[3*c+1], s[3*c+2]);
            o[c] = r[3];
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            st[d] = '0; gst[d] = '0; kr[d] = '0; sl[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [11:0] n, gn, lk;
        logic [3:0]  r;
        if (RST) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            lk = (d == 0) ? LK_A : LK_B;
            n  = st[d];
            gn = gst[d];
            if (scan_en) begin
                n = {st[d][10:0], scan_in};
            end else if (en) begin
                for (int c = 0; c < 4; c++) begin
                    r = s27f(G0[c], G1[c], G2[c], G3[c], st[d][3*c], st[d][3*c+1], st[d][3*c+2]);
                    n[3*c +: 3] = r[2:0] ^ kr[d][3*c +: 3] ^ lk[3*c +: 3];
                    r = s27f(G0[c], G1[c], G2[c], G3[c], gst[d][3*c], gst[d][3*c+1], gst[d][3*c+2]);
                    gn[3*c +: 3] = r[2:0];
                end
            end
            st[d]  = n;
            gst[d] = gn;
            if (ksh[d] && !sl[d]) kr[d] = {kin[d], kr[d][11:1]};
            if (kse[d]) sl[d] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_g;
        exp_g = model_g17(st[0]);
        chk("g17_a", g17_a, exp_g);
        exp_g = model_g17(st[1]);
        chk("g17_b", g17_b, exp_g);
        chk("scan_out_a", so_a, sl[0] ? 1'b0 : st[0][11]);
        chk("scan_out_b", so_b, st[1][11]);
        chk("sealed_a", ks_a, sl[0]);
        chk("sealed_b", ks_b, sl[1]);
        chk("state_a", st_a, st[0]);
        chk("state_b", st_b, st[1]);
        chk("key_a", key_a, kr[0]);
        chk("key_b", key_b, kr[1]);
        if (gold_on) begin
            if (g17_a !== model_g17(gst[0])) mism[0]++;
            if (g17_b !== model_g17(gst[1])) mism[1]++;
        end
        ga_last = g17_a; gb_last = g17_b; sa_last = so_a; sb_last = so_b;
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit
    // later, then the model follows the rising edge.
    task automatic cycle();
        #1;
        check_all();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic set_in(input logic [3:0] a, b, c, d, input logic e);
        G0 = a; G1 = b; G2 = c; G3 = d; en = e;
    endtask

    task automatic load_keys(input logic [11:0] ka, kb, input bit seal);
        for (int i = 0; i < 12; i++) begin
            kin = {kb[i], ka[i]};
            ksh = 2'b11;
            kse = (seal && i == 11) ? 2'b11 : 2'b00;
            cycle();
        end
        ksh = 2'b00; kse = 2'b00; kin = 2'b00;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   $urandom_range(0, 3) != 0);
            cycle();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        cycle();
        RST = 1'b0;
    endtask

    initial begin
        logic [11:0] rec_a, rec_b;
        int          nz;

        RST = 1'b1; scan_en = 0; scan_in = 0; kin = 0; ksh = 0; kse = 0;
        mism[0] = 0; mism[1] = 0;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        model_reset();
        @(negedge CLK);

        // Reset state: all inputs 0 with state 000 drives G17 high.
        cycle();
        chk("rst_g17_a", ga_last, 4'hF);
        chk("rst_g17_b", gb_last, 4'hF);
        chk("rst_so_a", sa_last, 1'b0);
        RST = 1'b0;

        // Load correct keys and seal on the final shift.
        load_keys(LK_A, LK_B, 1'b1);
        chk("lit_sealed_a", ks_a, 1'b1);
        chk("lit_key_b", key_b, LK_B);
        kin = 2'b11; ksh = 2'b11;
        cycle(); cycle();
        ksh = 2'b00;
        chk("lit_key_locked_b", key_b, LK_B);

        set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cycle(); cycle();
        chk("lit_zero_g17", ga_last, 4'hF);
        chk("lit_zero_state", st_b, 12'h000);

        // ch0 with G0=1, G3=1: G17=0 now, state becomes G6=1 after the edge.
        set_in(4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
        cycle();
        chk("lit_ch0_g17_a", ga_last[0], 1'b0);
        chk("lit_ch0_state_a", st_a[2:0], 3'b010);
        chk("lit_ch0_state_b", st_b[2:0], 3'b010);
        cycle();
        chk("lit_ch0_g17_next", gb_last[0], 1'b0);

        rand_cycles(200);

        // Wrong key on dut_a (ch0 G6 bit flipped); correct key on dut_b.
        do_reset();
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        load_keys(12'h002, LK_B, 1'b0);
        gold_on = 1;
        set_in(4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
        cycle();
        chk("lit_wrong_state_a", st_a[2:0], 3'b000);
        chk("lit_right_state_b", st_b[2:0], 3'b010);
        rand_cycles(200);
        gold_on = 0;
        chk("golden_mism_correct", mism[1], 0);
        chk("golden_mism_wrong_nonzero", (mism[0] > 0) ? 1 : 0, 1);

        // Scan shift-in then shift-out, en toggling throughout.
        scan_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            scan_in = PAT[11-i];
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), i[0]);
            cycle();
        end
        chk("lit_scan_loaded_b", st_b, PAT);
        for (int i = 0; i < 12; i++) begin
            scan_in = 1'b0;
            en = ~i[0];
            cycle();
            rec_a[11-i] = sa_last;
            rec_b[11-i] = sb_last;
        end
        chk("lit_scan_out_a", rec_a, PAT);
        chk("lit_scan_out_b", rec_b, PAT);
        scan_en = 1'b0;

        // Seal together with a final shift; that shift must land.
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        kin = 2'b01; ksh = 2'b11; kse = 2'b11;
        cycle();
        kse = 2'b00;
        chk("lit_seal_shift_a", key_a, 12'h801);
        chk("lit_seal_shift_b", key_b, 12'h362);
        kin = 2'b10;
        cycle(); cycle(); cycle();
        ksh = 2'b00;
        chk("lit_sealed_key_a", key_a, 12'h801);
        chk("lit_sealed_key_b", key_b, 12'h362);

        // Sealed: dut_a scan_out blanked while its chain still shifts.
        scan_en = 1'b1;
        nz = 0;
        for (int i = 0; i < 24; i++) begin
            scan_in = (i < 12) ? PAT[11-i] : 1'b0;
            en = i[0];
            cycle();
            if (sa_last !== 1'b0) nz++;
            if (i == 11) chk("lit_sealed_chain_a", st_a, PAT);
            if (i >= 12) rec_b[23-i] = sb_last;
        end
        chk("lit_blank_scan_a", nz, 0);
        chk("lit_unblanked_b", rec_b, PAT);
        scan_en = 1'b0;
        rand_cycles(30);

        // Asynchronous reset between edges, mid-scan and mid-key-load.
        scan_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            scan_in = 1'b1;
            kin = 2'b11; ksh = 2'b11;
            cycle();
        end
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("async_state_a", st_a, 12'h000);
        chk("async_state_b", st_b, 12'h000);
        chk("async_key_b", key_b, 12'h000);
        chk("async_sealed_a", ks_a, 1'b0);
        chk("async_so_b", so_b, 1'b0);
        @(negedge CLK);
        ksh = 2'b00; scan_en = 1'b0;
        cycle();
        RST = 1'b0;
        rand_cycles(20);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
